// File: rtl/parity_adder_pipe_if.sv
// Bus bundle for parity_adder_pipe: operand/result stream, stage holds,
// fault-injection controls and error reporting.
interface parity_adder_pipe_if #(
  parameter int WIDTH  = 4,
  parameter int LAYERS = 3,
  parameter int CNT_W  = 8
);
  localparam int LW = (LAYERS > 1) ? $clog2(LAYERS) : 1;

  logic [WIDTH-1:0]   input_vector;
  logic               in_valid;
  logic [LAYERS-1:0]  hold_signals;
  logic               inj_en;
  logic [LW-1:0]      inj_layer;
  logic [2*WIDTH-1:0] inj_mask;
  logic               err_clear;
  logic [WIDTH-1:0]   sum;
  logic               sum_valid;
  logic               Err_out_Final;
  logic [LAYERS-1:0]  err_sticky;
  logic [LW-1:0]      first_err_layer;
  logic [CNT_W-1:0]   err_count;

  modport master (
    output input_vector, in_valid, hold_signals, inj_en, inj_layer, inj_mask, err_clear,
    input  sum, sum_valid, Err_out_Final, err_sticky, first_err_layer, err_count
  );

  modport slave (
    input  input_vector, in_valid, hold_signals, inj_en, inj_layer, inj_mask, err_clear,
    output sum, sum_valid, Err_out_Final, err_sticky, first_err_layer, err_count
  );
endinterface

// File: rtl/parity_adder_pipe.sv
// Cascaded adder pipeline whose stage registers carry stored parity, with
// per-stage hold, fault injection and a hold-qualified error checker.
module parity_adder_pipe #(
  parameter int WIDTH  = 4,
  parameter int LAYERS = 3,
  parameter int CNT_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  parity_adder_pipe_if.slave bus
);
  localparam int LW = (LAYERS > 1) ? $clog2(LAYERS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  function automatic logic parity_f(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction

  // Index i holds stage i+1.
  logic [LAYERS-1:0][WIDTH-1:0] sum_r, delay_r;
  logic [LAYERS-1:0]            psum_r, pdel_r, valid_r;
  logic [LAYERS-1:0][WIDTH-1:0] res_in_s, b_in_s, sum_nxt_s, delay_nxt_s;
  logic [LAYERS-1:0]            valid_in_s, psum_nxt_s, pdel_nxt_s, valid_nxt_s;
  logic [LAYERS-1:0]            err_s, q_s;
  logic [LAYERS:0]              hold_ext_s;
  logic                         any_q_s;
  logic [LW-1:0]                low_q_s;
  logic [LAYERS-1:0]            sticky_r;
  logic [LW-1:0]                first_r;
  logic [CNT_W-1:0]             count_r;

  assign res_in_s   = {sum_r[LAYERS-2:0], bus.input_vector};
  assign b_in_s     = {delay_r[LAYERS-2:0], bus.input_vector};
  assign valid_in_s = {valid_r[LAYERS-2:0], bus.in_valid};
  // The last stage has no consumer, so its error is never masked.
  assign hold_ext_s = {1'b0, bus.hold_signals};

  // Next-state of every stage: advance or hold, then apply any injected flip.
  always_comb begin
    logic [WIDTH-1:0] sum_base_v;
    logic [WIDTH-1:0] del_base_v;
    sum_nxt_s   = '0;
    delay_nxt_s = '0;
    psum_nxt_s  = '0;
    pdel_nxt_s  = '0;
    valid_nxt_s = '0;
    sum_base_v  = '0;
    del_base_v  = '0;
    for (int i = 0; i < LAYERS; i++) begin
      if (bus.hold_signals[i]) begin
        sum_base_v     = sum_r[i];
        del_base_v     = delay_r[i];
        psum_nxt_s[i]  = psum_r[i];
        pdel_nxt_s[i]  = pdel_r[i];
        valid_nxt_s[i] = valid_r[i];
      end else begin
        sum_base_v     = res_in_s[i] + b_in_s[i];
        del_base_v     = b_in_s[i];
        psum_nxt_s[i]  = parity_f(sum_base_v);
        pdel_nxt_s[i]  = parity_f(del_base_v);
        valid_nxt_s[i] = valid_in_s[i];
      end
      if (bus.inj_en && (bus.inj_layer == LW'(i))) begin
        sum_nxt_s[i]   = sum_base_v ^ bus.inj_mask[WIDTH-1:0];
        delay_nxt_s[i] = del_base_v ^ bus.inj_mask[2*WIDTH-1:WIDTH];
      end else begin
        sum_nxt_s[i]   = sum_base_v;
        delay_nxt_s[i] = del_base_v;
      end
    end
  end

  // Parity check per stage, qualified by the downstream hold; lowest hit wins.
  always_comb begin
    err_s   = '0;
    q_s     = '0;
    low_q_s = '0;
    for (int i = 0; i < LAYERS; i++) begin
      err_s[i] = (psum_r[i] ^ parity_f(sum_r[i])) | (pdel_r[i] ^ parity_f(delay_r[i]));
      q_s[i]   = err_s[i] & ~hold_ext_s[i+1];
    end
    for (int i = LAYERS - 1; i >= 0; i--) begin
      if (q_s[i]) begin
        low_q_s = LW'(i);
      end else begin
        low_q_s = low_q_s;
      end
    end
    any_q_s = |q_s;
  end

  // Pipeline registers plus sticky flags, first-error capture and saturating counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_r    <= '0;
      delay_r  <= '0;
      psum_r   <= '0;
      pdel_r   <= '0;
      valid_r  <= '0;
      sticky_r <= '0;
      first_r  <= '0;
      count_r  <= '0;
    end else begin
      sum_r   <= sum_nxt_s;
      delay_r <= delay_nxt_s;
      psum_r  <= psum_nxt_s;
      pdel_r  <= pdel_nxt_s;
      valid_r <= valid_nxt_s;
      if (bus.err_clear) begin
        sticky_r <= q_s;
        first_r  <= any_q_s ? low_q_s : LW'(0);
        count_r  <= any_q_s ? CNT_W'(1) : CNT_W'(0);
      end else begin
        sticky_r <= sticky_r | q_s;
        if ((sticky_r == '0) && any_q_s) begin
          first_r <= low_q_s;
        end else begin
          first_r <= first_r;
        end
        if (any_q_s && (count_r != CNT_MAX)) begin
          count_r <= count_r + CNT_W'(1);
        end else begin
          count_r <= count_r;
        end
      end
    end
  end

  assign bus.sum             = sum_r[LAYERS-1];
  assign bus.sum_valid       = valid_r[LAYERS-1];
  assign bus.Err_out_Final   = any_q_s;
  assign bus.err_sticky      = sticky_r;
  assign bus.first_err_layer = first_r;
  assign bus.err_count       = count_r;
endmodule

// File: tb/tb_parity_adder_pipe.sv
// Scoreboard bench for parity_adder_pipe: directed sums checked by a monitor,
// directed fault-injection scenarios checked inline.
module tb_parity_adder_pipe;
  localparam int WIDTH  = 4;
  localparam int LAYERS = 3;
  localparam int CNT_W  = 8;

  typedef struct {
    logic [WIDTH-1:0] sum;
    int               cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  parity_adder_pipe_if #(.WIDTH(WIDTH), .LAYERS(LAYERS), .CNT_W(CNT_W)) bus();

  parity_adder_pipe #(.WIDTH(WIDTH), .LAYERS(LAYERS), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] v, input logic [WIDTH-1:0] exp_sum);
    exp_t e;
    bus.input_vector = v;
    bus.in_valid     = 1'b1;
    e.sum = exp_sum;
    e.cyc = cyc + LAYERS;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    bus.input_vector = '0;
    bus.in_valid     = 1'b0;
  endtask

  // Monitor: every valid output must match the oldest expectation, on time.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (bus.sum_valid === 1'b1)) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_sum actual=%0d required=no_output", bus.sum);
      end else begin
        e = exp_q.pop_front();
        chk("sum_value", bus.sum, e.sum);
        chk("sum_latency", cyc, e.cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    bus.hold_signals = '0;
    bus.inj_en       = 1'b0;
    bus.inj_layer    = '0;
    bus.inj_mask     = '0;
    bus.err_clear    = 1'b0;
    #12;
    chk("rst_sum", bus.sum, 0);
    chk("rst_valid", bus.sum_valid, 0);
    chk("rst_err", bus.Err_out_Final, 0);
    chk("rst_count", bus.err_count, 0);
    @(negedge clk);
    rst = 1'b0;

    // Data path: 4*x mod 16, three-cycle latency.
    tick();
    send(4'd3, 4'd12);
    tick();
    idle();
    repeat (4) begin
      tick();
      chk("err_quiet", bus.Err_out_Final, 0);
    end
    send(4'd5, 4'd4);
    tick();
    send(4'd1, 4'd4);
    tick();
    send(4'd2, 4'd8);
    tick();
    send(4'd3, 4'd12);
    tick();
    idle();
    repeat (5) tick();
    chk("data_sticky", bus.err_sticky, 0);
    chk("data_count", bus.err_count, 0);

    // Stage 2 corrupted while held; masked until its consumer is released.
    bus.hold_signals = 3'b110;
    bus.inj_en       = 1'b1;
    bus.inj_layer    = 2'd1;
    bus.inj_mask     = 8'h01;
    tick();
    bus.inj_en = 1'b0;
    chk("masked_err", bus.Err_out_Final, 0);
    tick();
    chk("masked_sticky", bus.err_sticky, 0);
    bus.hold_signals = 3'b010;
    #1;
    chk("unmasked_err", bus.Err_out_Final, 1);
    tick();
    chk("l1_sticky", bus.err_sticky, 3'b010);
    chk("l1_first", bus.first_err_layer, 1);
    chk("l1_count1", bus.err_count, 1);
    tick();
    chk("l1_count2", bus.err_count, 2);
    bus.hold_signals = 3'b000;
    #1;
    chk("l1_err_until_reload", bus.Err_out_Final, 1);
    tick();
    chk("l1_err_reloaded", bus.Err_out_Final, 0);
    chk("l1_count3", bus.err_count, 3);

    // Last stage: even-weight flip is invisible, one bit per register is caught.
    bus.err_clear = 1'b1;
    tick();
    bus.err_clear = 1'b0;
    chk("clr_count", bus.err_count, 0);
    chk("clr_sticky", bus.err_sticky, 0);
    chk("clr_first", bus.first_err_layer, 0);
    bus.inj_en    = 1'b1;
    bus.inj_layer = 2'd2;
    bus.inj_mask  = 8'h03;
    tick();
    bus.inj_en = 1'b0;
    chk("even_flip_sum", bus.sum, 3);
    chk("even_flip_err", bus.Err_out_Final, 0);
    tick();
    chk("even_flip_count", bus.err_count, 0);
    bus.inj_en   = 1'b1;
    bus.inj_mask = 8'h11;
    tick();
    bus.inj_en = 1'b0;
    chk("odd_flip_err", bus.Err_out_Final, 1);
    tick();
    chk("odd_flip_gone", bus.Err_out_Final, 0);
    chk("odd_flip_count", bus.err_count, 1);
    chk("odd_flip_sticky", bus.err_sticky, 3'b100);
    chk("odd_flip_first", bus.first_err_layer, 2);

    // Layers 0 then 2 on consecutive cycles; clear while layer 2 still errs.
    bus.err_clear = 1'b1;
    tick();
    bus.err_clear = 1'b0;
    bus.inj_en    = 1'b1;
    bus.inj_layer = 2'd0;
    bus.inj_mask  = 8'h01;
    tick();
    bus.inj_layer    = 2'd2;
    bus.hold_signals = 3'b100;
    tick();
    bus.inj_en = 1'b0;
    tick();
    chk("multi_sticky", bus.err_sticky, 3'b101);
    chk("multi_first", bus.first_err_layer, 0);
    chk("multi_count", bus.err_count, 2);
    bus.err_clear = 1'b1;
    tick();
    bus.err_clear = 1'b0;
    chk("clr_hit_count", bus.err_count, 1);
    chk("clr_hit_sticky", bus.err_sticky, 3'b100);
    chk("clr_hit_first", bus.first_err_layer, 2);

    // Persistent held error drives the counter into saturation.
    repeat (300) tick();
    chk("sat_count", bus.err_count, 255);
    chk("pre_rst_sum", bus.sum, 1);

    // Asynchronous reset mid-cycle.
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_sum", bus.sum, 0);
    chk("arst_valid", bus.sum_valid, 0);
    chk("arst_err", bus.Err_out_Final, 0);
    chk("arst_sticky", bus.err_sticky, 0);
    chk("arst_first", bus.first_err_layer, 0);
    chk("arst_count", bus.err_count, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.hold_signals = 3'b000;

    tick();
    send(4'd7, 4'd12);
    tick();
    idle();
    for (int n = 0; n < 10; n++) begin
      if (exp_q.size() != 0) tick();
    end
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
